syncfifo_width_conv: RTL and testbench
======================================

// Module: syncfifo_width_conv
// PURPOSE
//  Synchronous FIFO with din/dout width conversion at any integer ratio (3:1, 1:5, ...), not only powers of two.
//  Adds storage-level count, programmable thresholds, partial-word flush with per-slice keep, and sticky over/underflow.
//  Generalised successor of the power-of-two width-converting sync FIFO; used on same-clock datapath width boundaries.
// PARAMETERS
//  DIN_WIDTH      8              write data width
//  DOUT_WIDTH     32             read data width; max(DIN,DOUT) must equal R*min(DIN,DOUT), R integer >= 1
//  ADDR_WIDTH     4              storage depth D = 2**ADDR_WIDTH entries of max(DIN_WIDTH,DOUT_WIDTH) bits, >= 1
//  FWFT_EN        1              1: first-word fall-through; 0: standard read, dout valid 1 cycle after rd_en
//  MSB_FIRST      1              1: first narrow word occupies most-significant slice; 0: least-significant
//  PROG_FULL_TH   12             prog_full threshold, storage entries, 1..D
//  PROG_EMPTY_TH  2              prog_empty threshold, storage entries, 0..D-1
//  RAM_STYLE      "distributed"  storage implementation hint: "block" or "distributed"
// PORTS
//  clk         in   1             clock, all logic rising-edge
//  rst         in   1             reset, asynchronous, active-high
//  din         in   DIN_WIDTH     write data
//  wr_en       in   1             write request; accepted iff !full
//  wr_flush    in   1             pulse: commit partially packed wide word (upsize only; ignored when R==1 or downsize)
//  full        out  1             no write accepted this cycle
//  dout        out  DOUT_WIDTH    read data
//  dout_keep   out  KW            KW=R when upsizing else 1; bit i=1 -> slice i (in MSB_FIRST order) holds real data
//  rd_en       in   1             read request; accepted iff !empty
//  empty       out  1             no read accepted this cycle
//  data_count  out  ADDR_WIDTH+1  occupied storage entries, 0..D
//  prog_full   out  1             data_count >= PROG_FULL_TH
//  prog_empty  out  1             data_count <= PROG_EMPTY_TH
//  overflow    out  1             sticky: wr_en while full; cleared by rst only
//  underflow   out  1             sticky: rd_en while empty; cleared by rst only
// BEHAVIOUR
//  Reset: storage pointers, data_count, pack/unpack index, flush_pending = 0; full=0, empty=1, dout=0, dout_keep=0,
//   prog_full=0, prog_empty=1, overflow=underflow=0. rst mid-operation discards all data, pending flush included.
//  Storage: circular buffer, D entries + keep bits; write when !storage_full, pop when !storage_empty; simultaneous
//   write+pop leaves data_count unchanged; pointers wrap modulo D, extra MSB distinguishes full from empty.
//  Upsize (DOUT=R*DIN): packer holds pack_cnt (0..R-1) words; accepted din fills slice pack_cnt; on slice R-1 the
//   packed word (keep all ones) is written to storage same edge, pack_cnt->0.
//   full = (storage_full && pack_cnt==R-1) || flush_pending. Capacity: D*R+R-1 din words.
//   wr_flush with pack_cnt>0 (counting a same-cycle accepted din): commit packed slices, unused slices 0, keep bit=0.
//   If the same-cycle din completes the word, normal commit only. If storage full: set flush_pending, commit on first
//   cycle with space, clear pending. wr_flush with nothing packed: no-op.
//  Downsize (DIN=R*DOUT): din written directly to storage; full = storage_full. Unpacker index u (0..R-1) selects
//   slice u of head entry; accepted read advances u; read at u==R-1 pops entry, u->0. empty = storage_empty.
//  R==1: plain sync FIFO, dout_keep=1 with any valid dout.
//  FWFT_EN=1: dout/dout_keep combinationally reflect head slice whenever !empty; 0 latency from storage write to !empty
//   is NOT allowed: empty deasserts the cycle after the storage write edge.
//  FWFT_EN=0: dout/dout_keep registered, update the edge after an accepted rd_en, hold otherwise.
//  Flags/counts are combinational from registered state; overflow/underflow set on the edge of the offending request.
// TESTING
//  T1 up 8->24 (R=3), MSB_FIRST=1: write 0x11,0x22,0x33 -> empty falls; dout=0x112233, keep=3'b111.
//  T2 up R=3: write 0xAA, pulse wr_flush -> dout=0xAA0000, keep=3'b100; next 3 writes form a normal word.
//  T3 down 32->8 (R=4), MSB_FIRST=0: write 0x44332211 -> reads 0x11,0x22,0x33,0x44, then empty=1.
//  T4 fill up R=3, D=16 to 50 words -> full=1, data_count=16; extra wr_en -> overflow=1, data unchanged.
//  T5 storage full + pack_cnt=1, wr_flush -> full held; after 1 read flushed word lands at tail, full clears.
//  T6 FWFT_EN=0 read on empty -> underflow=1, dout holds; rst mid-stream -> empty=1, count=0, all flags reset.

Source files
------------

// File: rtl/syncfifo_width_conv_if.sv
`default_nettype none
// ============================================================================
//  Module      : syncfifo_width_conv_if
//  Description : Handshake/data bundle for the width-converting sync FIFO.
//                master = producer/consumer side, slave = the FIFO itself.
//                Write side : din, wr_en, wr_flush -> full
//                Read side  : rd_en -> dout, dout_keep, empty
//                Status     : data_count, prog_full, prog_empty,
//                             overflow, underflow
//  Revision    : 1.0  initial release
// ============================================================================
interface syncfifo_width_conv_if #(
    parameter int DIN_WIDTH  = 8,
    parameter int DOUT_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    // One keep bit per narrow slice when upsizing, a single bit otherwise.
    localparam int c_kw = (DOUT_WIDTH > DIN_WIDTH) ? (DOUT_WIDTH / DIN_WIDTH) : 1;

    logic [DIN_WIDTH-1:0]  din;
    logic                  wr_en;
    logic                  wr_flush;
    logic                  full;
    logic [DOUT_WIDTH-1:0] dout;
    logic [c_kw-1:0]       dout_keep;
    logic                  rd_en;
    logic                  empty;
    logic [ADDR_WIDTH:0]   data_count;
    logic                  prog_full;
    logic                  prog_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output din, wr_en, wr_flush, rd_en,
        input  full, dout, dout_keep, empty, data_count,
               prog_full, prog_empty, overflow, underflow
    );

    modport slave (
        input  din, wr_en, wr_flush, rd_en,
        output full, dout, dout_keep, empty, data_count,
               prog_full, prog_empty, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/syncfifo_width_conv.sv
`default_nettype none
// ============================================================================
//  Module      : syncfifo_width_conv
//  Description : Synchronous FIFO converting between din and dout widths at
//                any integer ratio R. Upsizing packs R narrow words per
//                storage entry (with partial-word flush and per-slice keep);
//                downsizing unpacks one wide entry over R reads.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous active-high reset
//                bus (slave)- din/wr_en/wr_flush/full, dout/dout_keep/rd_en/
//                             empty, data_count, prog_full/prog_empty,
//                             sticky overflow/underflow
//  Revision    : 1.0  initial release
// ============================================================================
module syncfifo_width_conv #(
    parameter int    DIN_WIDTH     = 8,
    parameter int    DOUT_WIDTH    = 32,
    parameter int    ADDR_WIDTH    = 4,
    parameter int    FWFT_EN       = 1,
    parameter int    MSB_FIRST     = 1,
    parameter int    PROG_FULL_TH  = 12,
    parameter int    PROG_EMPTY_TH = 2,
    parameter string RAM_STYLE     = "distributed"
) (
    input  wire                   clk,
    input  wire                   rst,
    syncfifo_width_conv_if.slave  bus
);

    localparam int c_wide   = (DIN_WIDTH > DOUT_WIDTH) ? DIN_WIDTH : DOUT_WIDTH;
    localparam int c_narrow = (DIN_WIDTH > DOUT_WIDTH) ? DOUT_WIDTH : DIN_WIDTH;
    localparam int c_r      = c_wide / c_narrow;
    localparam bit c_up     = (DOUT_WIDTH > DIN_WIDTH);
    localparam bit c_down   = (DIN_WIDTH > DOUT_WIDTH);
    localparam int c_kw     = c_up ? c_r : 1;
    localparam int c_cw     = (c_r > 1) ? $clog2(c_r) : 1;
    localparam int c_depth  = 1 << ADDR_WIDTH;
    localparam int c_aw     = (ADDR_WIDTH > 0) ? ADDR_WIDTH : 1;

    localparam logic [c_cw-1:0]     c_last  = c_cw'(c_r - 1);
    localparam logic [ADDR_WIDTH:0] c_pf_th = (ADDR_WIDTH + 1)'(PROG_FULL_TH);
    localparam logic [ADDR_WIDTH:0] c_pe_th = (ADDR_WIDTH + 1)'(PROG_EMPTY_TH);

    // ------------------------------------------------------------------
    // Storage pointers and status
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic [ADDR_WIDTH:0]   w_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_st_full;
    logic                  w_st_empty;
    logic                  w_st_wr;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [c_wide-1:0]     w_st_wdata;
    logic [c_kw-1:0]       w_st_wkeep;
    logic [c_wide-1:0]     w_head;
    logic [c_kw-1:0]       w_head_keep;
    logic [c_aw-1:0]       w_waddr;
    logic [c_aw-1:0]       w_raddr;
    logic [DOUT_WIDTH-1:0] w_rd_data;
    logic [c_kw-1:0]       w_rd_keep;

    // Depth is a power of two, so the count MSB is set only at exactly D.
    assign w_count    = r_wptr - r_rptr;
    assign w_st_empty = (r_wptr == r_rptr);
    assign w_st_full  = w_count[ADDR_WIDTH];
    assign w_empty    = w_st_empty;
    assign w_wr_acc   = bus.wr_en && !w_full;
    assign w_rd_acc   = bus.rd_en && !w_empty;
    assign w_waddr    = (ADDR_WIDTH > 0) ? r_wptr[c_aw-1:0] : '0;
    assign w_raddr    = (ADDR_WIDTH > 0) ? r_rptr[c_aw-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_st_wr)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (bus.wr_en && w_full)
                r_overflow <= 1'b1;
            if (bus.rd_en && w_empty)
                r_underflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Storage array (data + keep), asynchronous read of the head entry
    // ------------------------------------------------------------------
    if (RAM_STYLE == "block") begin : g_mem_block
        (* ram_style = "block" *) logic [c_wide-1:0] r_mem  [0:c_depth-1];
        (* ram_style = "block" *) logic [c_kw-1:0]   r_kmem [0:c_depth-1];

        always_ff @(posedge clk) begin
            if (w_st_wr) begin
                r_mem[w_waddr]  <= w_st_wdata;
                r_kmem[w_waddr] <= w_st_wkeep;
            end
        end

        assign w_head      = r_mem[w_raddr];
        assign w_head_keep = r_kmem[w_raddr];
    end else begin : g_mem_dist
        (* ram_style = "distributed" *) logic [c_wide-1:0] r_mem  [0:c_depth-1];
        (* ram_style = "distributed" *) logic [c_kw-1:0]   r_kmem [0:c_depth-1];

        always_ff @(posedge clk) begin
            if (w_st_wr) begin
                r_mem[w_waddr]  <= w_st_wdata;
                r_kmem[w_waddr] <= w_st_wkeep;
            end
        end

        assign w_head      = r_mem[w_raddr];
        assign w_head_keep = r_kmem[w_raddr];
    end

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    if (c_up) begin : g_pack
        logic [c_wide-1:0] r_pack;
        logic [c_cw-1:0]   r_pack_cnt;
        logic              r_flush_pending;
        logic [c_wide-1:0] w_pack_nxt;
        logic [c_cw:0]     w_cnt_eff;
        logic [c_kw-1:0]   w_part_keep;
        logic              w_complete;
        logic              w_flush_req;

        // Words held after this cycle's accepted din (if any).
        assign w_cnt_eff = {1'b0, r_pack_cnt} + {{c_cw{1'b0}}, w_wr_acc};

        always_comb begin
            w_pack_nxt  = r_pack;
            w_part_keep = '0;
            for (int k = 0; k < c_r; k++) begin
                if (w_wr_acc && (k == int'(r_pack_cnt)))
                    w_pack_nxt[((MSB_FIRST != 0) ? (c_r - 1 - k) : k) * c_narrow +: c_narrow] = bus.din;
                if (k < int'(w_cnt_eff))
                    w_part_keep[(MSB_FIRST != 0) ? (c_r - 1 - k) : k] = 1'b1;
            end
        end

        assign w_complete  = w_wr_acc && (r_pack_cnt == c_last);
        // A din that completes the word turns a flush into a normal commit.
        assign w_flush_req = r_flush_pending ||
                             (bus.wr_flush && !w_complete && (w_cnt_eff != '0));
        // A pending flush blocks writes so the partial word cannot grow.
        assign w_full      = (w_st_full && (r_pack_cnt == c_last)) || r_flush_pending;
        assign w_st_wr     = w_complete || (w_flush_req && !w_st_full);
        assign w_st_wdata  = w_pack_nxt;
        assign w_st_wkeep  = w_complete ? '1 : w_part_keep;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pack          <= '0;
                r_pack_cnt      <= '0;
                r_flush_pending <= 1'b0;
            end else if (w_st_wr) begin
                // Clear so unused slices of the next partial word read as 0.
                r_pack          <= '0;
                r_pack_cnt      <= '0;
                r_flush_pending <= 1'b0;
            end else if (w_flush_req) begin
                r_pack          <= w_pack_nxt;
                r_pack_cnt      <= w_cnt_eff[c_cw-1:0];
                r_flush_pending <= 1'b1;
            end else if (w_wr_acc) begin
                r_pack          <= w_pack_nxt;
                r_pack_cnt      <= r_pack_cnt + 1'b1;
            end
        end
    end else begin : g_direct
        logic w_unused_flush;

        assign w_unused_flush = bus.wr_flush;
        assign w_full         = w_st_full;
        assign w_st_wr        = w_wr_acc;
        assign w_st_wdata     = bus.din;
        assign w_st_wkeep     = '1;
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    if (c_down) begin : g_unpack
        logic [c_cw-1:0] r_unpk;

        always_comb begin
            w_rd_data = '0;
            for (int k = 0; k < c_r; k++) begin
                if (k == int'(r_unpk))
                    w_rd_data = w_head[((MSB_FIRST != 0) ? (c_r - 1 - k) : k) * c_narrow +: c_narrow];
            end
        end

        assign w_rd_keep = w_head_keep;
        assign w_pop     = w_rd_acc && (r_unpk == c_last);

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r_unpk <= '0;
            else if (w_rd_acc)
                r_unpk <= (r_unpk == c_last) ? '0 : (r_unpk + 1'b1);
        end
    end else begin : g_whole
        assign w_rd_data = w_head;
        assign w_rd_keep = w_head_keep;
        assign w_pop     = w_rd_acc;
    end

    if (FWFT_EN != 0) begin : g_fwft
        assign bus.dout      = w_empty ? '0 : w_rd_data;
        assign bus.dout_keep = w_empty ? '0 : w_rd_keep;
    end else begin : g_std
        logic [DOUT_WIDTH-1:0] r_dout;
        logic [c_kw-1:0]       r_keep;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_dout <= '0;
                r_keep <= '0;
            end else if (w_rd_acc) begin
                r_dout <= w_rd_data;
                r_keep <= w_rd_keep;
            end
        end

        assign bus.dout      = r_dout;
        assign bus.dout_keep = r_keep;
    end

    // ------------------------------------------------------------------
    // Flags
    // ------------------------------------------------------------------
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.data_count = w_count;
    assign bus.prog_full  = (w_count >= c_pf_th);
    assign bus.prog_empty = (w_count <= c_pe_th);
    assign bus.overflow   = r_overflow;
    assign bus.underflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_syncfifo_width_conv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_syncfifo_width_conv
//  Description : Directed self-checking bench for syncfifo_width_conv.
//                u_up  : 8->24  upsize, FWFT, MSB first, D=16
//                u_dn  : 32->8  downsize, FWFT, LSB first, D=16
//                u_std : 8->24  upsize, standard read, MSB first, D=4
//  Revision    : 1.0  initial release
// ============================================================================
module tb_syncfifo_width_conv;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    syncfifo_width_conv_if #(.DIN_WIDTH(8),  .DOUT_WIDTH(24), .ADDR_WIDTH(4)) if_up ();
    syncfifo_width_conv_if #(.DIN_WIDTH(32), .DOUT_WIDTH(8),  .ADDR_WIDTH(4)) if_dn ();
    syncfifo_width_conv_if #(.DIN_WIDTH(8),  .DOUT_WIDTH(24), .ADDR_WIDTH(2)) if_std ();

    syncfifo_width_conv #(
        .DIN_WIDTH(8), .DOUT_WIDTH(24), .ADDR_WIDTH(4), .FWFT_EN(1), .MSB_FIRST(1),
        .PROG_FULL_TH(12), .PROG_EMPTY_TH(2), .RAM_STYLE("distributed")
    ) u_up (.clk(clk), .rst(rst), .bus(if_up));

    syncfifo_width_conv #(
        .DIN_WIDTH(32), .DOUT_WIDTH(8), .ADDR_WIDTH(4), .FWFT_EN(1), .MSB_FIRST(0),
        .PROG_FULL_TH(12), .PROG_EMPTY_TH(2), .RAM_STYLE("block")
    ) u_dn (.clk(clk), .rst(rst), .bus(if_dn));

    syncfifo_width_conv #(
        .DIN_WIDTH(8), .DOUT_WIDTH(24), .ADDR_WIDTH(2), .FWFT_EN(0), .MSB_FIRST(1),
        .PROG_FULL_TH(3), .PROG_EMPTY_TH(1), .RAM_STYLE("distributed")
    ) u_std (.clk(clk), .rst(rst), .bus(if_std));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic up_wr(input logic [7:0] d, input logic fl);
        if_up.din = d; if_up.wr_en = 1'b1; if_up.wr_flush = fl;
        tick();
        if_up.wr_en = 1'b0; if_up.wr_flush = 1'b0;
    endtask

    task automatic up_fl;
        if_up.wr_flush = 1'b1; tick(); if_up.wr_flush = 1'b0;
    endtask

    task automatic up_rd;
        if_up.rd_en = 1'b1; tick(); if_up.rd_en = 1'b0;
    endtask

    task automatic dn_wr(input logic [31:0] d);
        if_dn.din = d; if_dn.wr_en = 1'b1; tick(); if_dn.wr_en = 1'b0;
    endtask

    task automatic dn_rd;
        if_dn.rd_en = 1'b1; tick(); if_dn.rd_en = 1'b0;
    endtask

    task automatic std_wr(input logic [7:0] d);
        if_std.din = d; if_std.wr_en = 1'b1; tick(); if_std.wr_en = 1'b0;
    endtask

    task automatic std_rd;
        if_std.rd_en = 1'b1; tick(); if_std.rd_en = 1'b0;
    endtask

    task automatic test_reset;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_checks++; if (if_up.empty !== 1'b1) begin n_errors++; $display("FAIL rst_up_empty: got %b expected 1", if_up.empty); end
        n_checks++; if (if_up.full !== 1'b0) begin n_errors++; $display("FAIL rst_up_full: got %b expected 0", if_up.full); end
        n_checks++; if (if_up.data_count !== 5'd0) begin n_errors++; $display("FAIL rst_up_count: got %0d expected 0", if_up.data_count); end
        n_checks++; if (if_up.dout !== 24'h0) begin n_errors++; $display("FAIL rst_up_dout: got %h expected 000000", if_up.dout); end
        n_checks++; if (if_up.dout_keep !== 3'b000) begin n_errors++; $display("FAIL rst_up_keep: got %b expected 000", if_up.dout_keep); end
        n_checks++; if (if_up.prog_empty !== 1'b1 || if_up.prog_full !== 1'b0) begin n_errors++; $display("FAIL rst_up_prog: got pe=%b pf=%b expected pe=1 pf=0", if_up.prog_empty, if_up.prog_full); end
        n_checks++; if (if_up.overflow !== 1'b0 || if_up.underflow !== 1'b0) begin n_errors++; $display("FAIL rst_up_sticky: got ov=%b un=%b expected 0 0", if_up.overflow, if_up.underflow); end
        n_checks++; if (if_dn.empty !== 1'b1) begin n_errors++; $display("FAIL rst_dn_empty: got %b expected 1", if_dn.empty); end
        n_checks++; if (if_std.dout !== 24'h0 || if_std.empty !== 1'b1) begin n_errors++; $display("FAIL rst_std: got dout=%h empty=%b expected 000000 1", if_std.dout, if_std.empty); end
    endtask

    task automatic test_upsize;
        up_wr(8'h11, 1'b0);
        up_wr(8'h22, 1'b0);
        n_checks++; if (if_up.empty !== 1'b1) begin n_errors++; $display("FAIL up_partial_empty: got %b expected 1", if_up.empty); end
        up_wr(8'h33, 1'b0);
        n_checks++; if (if_up.empty !== 1'b0) begin n_errors++; $display("FAIL up_word_empty: got %b expected 0", if_up.empty); end
        n_checks++; if (if_up.dout !== 24'h112233) begin n_errors++; $display("FAIL up_word_dout: got %h expected 112233", if_up.dout); end
        n_checks++; if (if_up.dout_keep !== 3'b111) begin n_errors++; $display("FAIL up_word_keep: got %b expected 111", if_up.dout_keep); end
        n_checks++; if (if_up.data_count !== 5'd1) begin n_errors++; $display("FAIL up_word_count: got %0d expected 1", if_up.data_count); end
        up_rd();
        n_checks++; if (if_up.empty !== 1'b1) begin n_errors++; $display("FAIL up_drain_empty: got %b expected 1", if_up.empty); end
    endtask

    task automatic test_flush;
        up_wr(8'hAA, 1'b0);
        up_fl();
        n_checks++; if (if_up.dout !== 24'hAA0000 || if_up.dout_keep !== 3'b100) begin n_errors++; $display("FAIL flush_partial: got %h/%b expected aa0000/100", if_up.dout, if_up.dout_keep); end
        n_checks++; if (if_up.data_count !== 5'd1) begin n_errors++; $display("FAIL flush_count: got %0d expected 1", if_up.data_count); end
        up_rd();
        // din completing the word in the same cycle as wr_flush: normal commit.
        up_wr(8'h01, 1'b0);
        up_wr(8'h02, 1'b0);
        up_wr(8'h03, 1'b1);
        n_checks++; if (if_up.dout !== 24'h010203 || if_up.dout_keep !== 3'b111) begin n_errors++; $display("FAIL flush_complete: got %h/%b expected 010203/111", if_up.dout, if_up.dout_keep); end
        up_fl();
        n_checks++; if (if_up.data_count !== 5'd1) begin n_errors++; $display("FAIL flush_noop_count: got %0d expected 1", if_up.data_count); end
        up_rd();
        n_checks++; if (if_up.empty !== 1'b1) begin n_errors++; $display("FAIL flush_drain_empty: got %b expected 1", if_up.empty); end
        // Flush with only the same-cycle din packed.
        up_wr(8'h5A, 1'b1);
        n_checks++; if (if_up.dout !== 24'h5A0000 || if_up.dout_keep !== 3'b100) begin n_errors++; $display("FAIL flush_same_cycle: got %h/%b expected 5a0000/100", if_up.dout, if_up.dout_keep); end
        up_rd();
    endtask

    task automatic test_downsize;
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        dn_wr(32'h44332211);
        n_checks++; if (if_dn.empty !== 1'b0 || if_dn.data_count !== 5'd1) begin n_errors++; $display("FAIL dn_written: got empty=%b count=%0d expected 0 1", if_dn.empty, if_dn.data_count); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (if_dn.dout !== exp_b[i] || if_dn.dout_keep !== 1'b1) begin n_errors++; $display("FAIL dn_slice%0d: got %h/%b expected %h/1", i, if_dn.dout, if_dn.dout_keep, exp_b[i]); end
            dn_rd();
        end
        n_checks++; if (if_dn.empty !== 1'b1 || if_dn.data_count !== 5'd0) begin n_errors++; $display("FAIL dn_drained: got empty=%b count=%0d expected 1 0", if_dn.empty, if_dn.data_count); end
    endtask

    task automatic test_fill;
        logic [23:0] exp_w;
        for (int i = 0; i < 50; i++) up_wr(8'(i + 1), 1'b0);
        n_checks++; if (if_up.full !== 1'b1 || if_up.data_count !== 5'd16) begin n_errors++; $display("FAIL fill_full: got full=%b count=%0d expected 1 16", if_up.full, if_up.data_count); end
        n_checks++; if (if_up.prog_full !== 1'b1 || if_up.prog_empty !== 1'b0 || if_up.overflow !== 1'b0) begin n_errors++; $display("FAIL fill_flags: got pf=%b pe=%b ov=%b expected 1 0 0", if_up.prog_full, if_up.prog_empty, if_up.overflow); end
        up_wr(8'hEE, 1'b0);
        n_checks++; if (if_up.overflow !== 1'b1 || if_up.data_count !== 5'd16) begin n_errors++; $display("FAIL fill_overflow: got ov=%b count=%0d expected 1 16", if_up.overflow, if_up.data_count); end
        for (int k = 0; k < 16; k++) begin
            exp_w = {8'(3 * k + 1), 8'(3 * k + 2), 8'(3 * k + 3)};
            n_checks++; if (if_up.dout !== exp_w) begin n_errors++; $display("FAIL fill_entry%0d: got %h expected %h", k, if_up.dout, exp_w); end
            up_rd();
        end
        // Words 49 and 50 are still packed; 0xEE must not have been taken.
        up_wr(8'h33, 1'b0);
        n_checks++; if (if_up.dout !== 24'h313233 || if_up.data_count !== 5'd1) begin n_errors++; $display("FAIL fill_tail: got %h count=%0d expected 313233 1", if_up.dout, if_up.data_count); end
        up_rd();
    endtask

    task automatic test_flush_full;
        logic [23:0] exp_w;
        for (int i = 0; i < 48; i++) up_wr(8'(i + 1), 1'b0);
        up_wr(8'h70, 1'b0);
        n_checks++; if (if_up.full !== 1'b0) begin n_errors++; $display("FAIL ff_one_packed: got full=%b expected 0", if_up.full); end
        up_fl();
        n_checks++; if (if_up.full !== 1'b1 || if_up.data_count !== 5'd16) begin n_errors++; $display("FAIL ff_pending: got full=%b count=%0d expected 1 16", if_up.full, if_up.data_count); end
        n_checks++; if (if_up.dout !== 24'h010203) begin n_errors++; $display("FAIL ff_head: got %h expected 010203", if_up.dout); end
        up_rd();
        n_checks++; if (if_up.full !== 1'b1 || if_up.data_count !== 5'd15) begin n_errors++; $display("FAIL ff_after_read: got full=%b count=%0d expected 1 15", if_up.full, if_up.data_count); end
        tick();
        n_checks++; if (if_up.full !== 1'b0 || if_up.data_count !== 5'd16) begin n_errors++; $display("FAIL ff_committed: got full=%b count=%0d expected 0 16", if_up.full, if_up.data_count); end
        for (int k = 1; k < 16; k++) begin
            exp_w = {8'(3 * k + 1), 8'(3 * k + 2), 8'(3 * k + 3)};
            n_checks++; if (if_up.dout !== exp_w) begin n_errors++; $display("FAIL ff_entry%0d: got %h expected %h", k, if_up.dout, exp_w); end
            up_rd();
        end
        n_checks++; if (if_up.dout !== 24'h700000 || if_up.dout_keep !== 3'b100) begin n_errors++; $display("FAIL ff_tail: got %h/%b expected 700000/100", if_up.dout, if_up.dout_keep); end
        up_rd();
        n_checks++; if (if_up.empty !== 1'b1) begin n_errors++; $display("FAIL ff_drained: got empty=%b expected 1", if_up.empty); end
    endtask

    task automatic test_std_read_reset;
        std_wr(8'h11); std_wr(8'h22); std_wr(8'h33);
        n_checks++; if (if_std.empty !== 1'b0 || if_std.dout !== 24'h0) begin n_errors++; $display("FAIL std_before_read: got empty=%b dout=%h expected 0 000000", if_std.empty, if_std.dout); end
        std_rd();
        n_checks++; if (if_std.dout !== 24'h112233 || if_std.dout_keep !== 3'b111) begin n_errors++; $display("FAIL std_read: got %h/%b expected 112233/111", if_std.dout, if_std.dout_keep); end
        std_rd();
        n_checks++; if (if_std.underflow !== 1'b1 || if_std.dout !== 24'h112233) begin n_errors++; $display("FAIL std_underflow: got un=%b dout=%h expected 1 112233", if_std.underflow, if_std.dout); end
        for (int i = 0; i < 12; i++) std_wr(8'(8'h40 + i));
        std_wr(8'h99);
        if_std.wr_flush = 1'b1; tick(); if_std.wr_flush = 1'b0;
        n_checks++; if (if_std.full !== 1'b1 || if_std.data_count !== 3'd4 || if_std.prog_full !== 1'b1) begin n_errors++; $display("FAIL std_pending: got full=%b count=%0d pf=%b expected 1 4 1", if_std.full, if_std.data_count, if_std.prog_full); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (if_std.empty !== 1'b1 || if_std.full !== 1'b0 || if_std.data_count !== 3'd0) begin n_errors++; $display("FAIL std_rst_state: got empty=%b full=%b count=%0d expected 1 0 0", if_std.empty, if_std.full, if_std.data_count); end
        n_checks++; if (if_std.underflow !== 1'b0 || if_std.dout !== 24'h0 || if_std.dout_keep !== 3'b000) begin n_errors++; $display("FAIL std_rst_out: got un=%b dout=%h keep=%b expected 0 000000 000", if_std.underflow, if_std.dout, if_std.dout_keep); end
        n_checks++; if (if_std.prog_empty !== 1'b1 || if_std.prog_full !== 1'b0 || if_up.overflow !== 1'b0) begin n_errors++; $display("FAIL std_rst_flags: got pe=%b pf=%b up_ov=%b expected 1 0 0", if_std.prog_empty, if_std.prog_full, if_up.overflow); end
        std_wr(8'hA1); std_wr(8'hA2); std_wr(8'hA3);
        std_rd();
        n_checks++; if (if_std.dout !== 24'hA1A2A3) begin n_errors++; $display("FAIL std_after_rst: got %h expected a1a2a3", if_std.dout); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        if_up.din = '0;  if_up.wr_en = 1'b0;  if_up.wr_flush = 1'b0;  if_up.rd_en = 1'b0;
        if_dn.din = '0;  if_dn.wr_en = 1'b0;  if_dn.wr_flush = 1'b0;  if_dn.rd_en = 1'b0;
        if_std.din = '0; if_std.wr_en = 1'b0; if_std.wr_flush = 1'b0; if_std.rd_en = 1'b0;

        test_reset();
        test_upsize();
        test_flush();
        test_downsize();
        test_fill();
        test_flush_full();
        test_std_read_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
